// File: rtl/clock_pkg.sv
// Shared types and constants for the 24-hour time-of-day controller.
// Holds the mode encoding, the field widths and the default wrap limits.
package clock_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      SET_H = 2'd1,
      SET_M = 2'd2
   } mode_t;

   localparam int HOUR_W = 5;
   localparam int MIN_W  = 6;
   localparam int SEC_W  = 6;

   localparam int HOURS_MAX_DEF   = 23;
   localparam int MINUTES_MAX_DEF = 59;
   localparam int SECONDS_MAX_DEF = 59;

endpackage

// File: rtl/mod_counter.sv
// Modulo-(MAX+1) counter with synchronous clear. wrap flags the increment that
// rolls MAX over to 0 so the caller can chain carries in the same cycle.
module mod_counter #(
   parameter int WIDTH = 6,
   parameter int MAX   = 59
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] value,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         value <= '0;
      end else if (clr) begin
         value <= '0;
      end else if (inc) begin
         // An out-of-range value (>= MAX) reloads 0 rather than counting on.
         value <= (value >= MAX_V) ? '0 : value + WIDTH'(1);
      end
   end

   assign wrap = inc & (value == MAX_V);

endmodule

// File: rtl/clock_timekeeper.sv
// Time-of-day controller: hh:mm:ss counters, RUN/SET_H/SET_M set-mode FSM and
// display field blanking. Define CLOCK_BLINK_EN to build the blink phase logic.
module clock_timekeeper
   import clock_pkg::*;
#(
   parameter int HOURS_MAX   = HOURS_MAX_DEF,
   parameter int MINUTES_MAX = MINUTES_MAX_DEF,
   parameter int SECONDS_MAX = SECONDS_MAX_DEF
) (
   input  logic              clk_in,
   input  logic              rst,
   input  logic              s_tick,
   input  logic              hs_tick,
   input  logic              btn_mode,
   input  logic              btn_inc,
   output logic [HOUR_W-1:0] hours,
   output logic [MIN_W-1:0]  minutes,
   output logic [SEC_W-1:0]  seconds,
   output logic [1:0]        mode,
   output logic              blank_h,
   output logic              blank_m,
   output logic              day_wrap
);

   mode_t state, next_state;
   logic  sec_inc, sec_clr, min_set, hour_set;
   logic  min_inc, hour_inc;
   logic  sec_wrap, min_wrap, hour_wrap;

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) state <= RUN;
      else     state <= next_state;
   end

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      next_state = state;
      sec_inc    = 1'b0;
      sec_clr    = 1'b0;
      min_set    = 1'b0;
      hour_set   = 1'b0;
      case (state)
         RUN: begin
            if (btn_mode) begin
               next_state = SET_H;
               sec_clr    = 1'b1;
            end else begin
               sec_inc = s_tick;
            end
         end
         SET_H: begin
            sec_clr = 1'b1;
            if (btn_mode) next_state = SET_M;
            else          hour_set   = btn_inc;
         end
         SET_M: begin
            sec_clr = 1'b1;
            if (btn_mode) next_state = RUN;
            else          min_set    = btn_inc;
         end
         default: begin
            next_state = RUN;
            sec_clr    = 1'b1;
         end
      endcase
   end

   // Only the seconds carry may ripple into hours; a minute set never does.
   assign min_inc  = min_set | sec_wrap;
   assign hour_inc = hour_set | (sec_wrap & min_wrap);

   mod_counter #(.WIDTH(SEC_W), .MAX(SECONDS_MAX)) u_sec (
      .clk_in (clk_in),
      .rst    (rst),
      .inc    (sec_inc),
      .clr    (sec_clr),
      .value  (seconds),
      .wrap   (sec_wrap)
   );

   mod_counter #(.WIDTH(MIN_W), .MAX(MINUTES_MAX)) u_min (
      .clk_in (clk_in),
      .rst    (rst),
      .inc    (min_inc),
      .clr    (1'b0),
      .value  (minutes),
      .wrap   (min_wrap)
   );

   mod_counter #(.WIDTH(HOUR_W), .MAX(HOURS_MAX)) u_hour (
      .clk_in (clk_in),
      .rst    (rst),
      .inc    (hour_inc),
      .clr    (1'b0),
      .value  (hours),
      .wrap   (hour_wrap)
   );

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) day_wrap <= 1'b0;
      else     day_wrap <= sec_wrap & min_wrap & hour_wrap;
   end

   assign mode = state;

`ifdef CLOCK_BLINK_EN
   logic phase;

   // Phase restarts at 0 on each state entry so the selected field starts visible.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst)                              phase <= 1'b0;
      else if (next_state != state)         phase <= 1'b0;
      else if (state != RUN && hs_tick)     phase <= ~phase;
   end

   assign blank_h = (state == SET_H) & phase;
   assign blank_m = (state == SET_M) & phase;
`else
   logic unused_hs_tick;
   assign unused_hs_tick = hs_tick;
   assign blank_h        = 1'b0;
   assign blank_m        = 1'b0;
`endif

endmodule

// File: tb/tb_clock_timekeeper.sv
// Directed self-checking bench for clock_timekeeper; blink expectations follow
// CLOCK_BLINK_EN so the same bench covers both builds.
module tb_clock_timekeeper;

   logic       clk_in = 1'b0;
   logic       rst;
   logic       s_tick, hs_tick, btn_mode, btn_inc;
   logic [4:0] hours;
   logic [5:0] minutes, seconds;
   logic [1:0] mode;
   logic       blank_h, blank_m, day_wrap;

   int n_cmp  = 0;
   int n_fail = 0;

`ifdef CLOCK_BLINK_EN
   localparam logic BLINK = 1'b1;
`else
   localparam logic BLINK = 1'b0;
`endif

   clock_timekeeper dut (
      .clk_in   (clk_in),
      .rst      (rst),
      .s_tick   (s_tick),
      .hs_tick  (hs_tick),
      .btn_mode (btn_mode),
      .btn_inc  (btn_inc),
      .hours    (hours),
      .minutes  (minutes),
      .seconds  (seconds),
      .mode     (mode),
      .blank_h  (blank_h),
      .blank_m  (blank_m),
      .day_wrap (day_wrap)
   );

   always #10 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Called at a negedge: holds the given inputs over one posedge, then clears
   // them; outputs are sampled by the caller at the following negedge.
   task automatic pulse(input logic s, input logic hs, input logic m, input logic i);
      s_tick = s; hs_tick = hs; btn_mode = m; btn_inc = i;
      @(negedge clk_in);
      s_tick = 1'b0; hs_tick = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
   endtask

   task automatic check_time(input string tag, input int h, input int m, input int s);
      check({tag, " hours"},   32'(hours),   32'(h));
      check({tag, " minutes"}, 32'(minutes), 32'(m));
      check({tag, " seconds"}, 32'(seconds), 32'(s));
   endtask

   initial begin
      logic wrap_seen;
      rst = 1'b1; s_tick = 1'b0; hs_tick = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
      repeat (2) @(negedge clk_in);
      check_time("reset", 0, 0, 0);
      check("reset mode", 32'(mode), 0);
      check("reset day_wrap", 32'(day_wrap), 0);
      check("reset blank_h", 32'(blank_h), 0);
      check("reset blank_m", 32'(blank_m), 0);
      rst = 1'b0;
      @(negedge clk_in);

      // 61 seconds in RUN
      wrap_seen = 1'b0;
      for (int k = 0; k < 61; k++) begin
         pulse(1, 0, 0, 0);
         wrap_seen |= day_wrap;
      end
      check_time("61 ticks", 0, 1, 1);
      check("61 ticks no day_wrap", 32'(wrap_seen), 0);

      // preload 23:59 via set mode
      pulse(0, 0, 1, 0);
      check("enter SET_H mode", 32'(mode), 1);
      check("enter SET_H seconds cleared", 32'(seconds), 0);
      pulse(1, 0, 0, 0);
      check("SET_H s_tick ignored", 32'(seconds), 0);
      for (int k = 0; k < 23; k++) pulse(0, 0, 0, 1);
      pulse(0, 0, 1, 0);
      check("enter SET_M mode", 32'(mode), 2);
      for (int k = 0; k < 58; k++) pulse(0, 0, 0, 1);
      check_time("preload", 23, 59, 0);
      pulse(0, 0, 1, 0);
      check("back to RUN", 32'(mode), 0);
      for (int k = 0; k < 58; k++) pulse(1, 0, 0, 0);
      check_time("at 58", 23, 59, 58);
      pulse(1, 0, 0, 0);
      check_time("at 59", 23, 59, 59);
      check("day_wrap low at 59", 32'(day_wrap), 0);
      pulse(1, 0, 0, 0);
      check_time("midnight", 0, 0, 0);
      check("day_wrap at midnight", 32'(day_wrap), 1);
      @(negedge clk_in);
      check("day_wrap one cycle", 32'(day_wrap), 0);

      // hour and minute set wrap, no carry
      pulse(0, 0, 1, 0);
      for (int k = 0; k < 25; k++) pulse(0, 0, 0, 1);
      check("hours 25 incs", 32'(hours), 1);
      pulse(0, 0, 1, 0);
      for (int k = 0; k < 60; k++) pulse(0, 0, 0, 1);
      check_time("minutes 60 incs", 1, 0, 0);
      pulse(0, 0, 1, 0);
      check("return RUN mode", 32'(mode), 0);
      check("return RUN seconds", 32'(seconds), 0);
      pulse(0, 0, 0, 1);
      check_time("btn_inc ignored in RUN", 1, 0, 0);

      // simultaneous events
      pulse(0, 0, 1, 1);
      check("mode+inc mode", 32'(mode), 1);
      check("mode+inc hours", 32'(hours), 1);
      pulse(0, 0, 1, 0);
      pulse(0, 0, 1, 0);
      for (int k = 0; k < 30; k++) pulse(1, 0, 0, 0);
      check("seconds 30", 32'(seconds), 30);
      pulse(1, 0, 1, 0);
      check("mode+tick mode", 32'(mode), 1);
      check("mode+tick seconds", 32'(seconds), 0);

      // blink: SET_H toggles blank_h, entry to SET_M clears phase
      pulse(0, 1, 0, 0);
      check("SET_H blink blank_h", 32'(blank_h), 32'(BLINK));
      check("SET_H blink blank_m", 32'(blank_m), 0);
      pulse(0, 0, 1, 0);
      check("SET_M entry blank_h", 32'(blank_h), 0);
      check("SET_M entry blank_m", 32'(blank_m), 0);
      for (int k = 0; k < 4; k++) begin
         pulse((k == 0) ? 1'b1 : 1'b0, 1, 0, 0);
         check($sformatf("SET_M blink %0d blank_m", k), 32'(blank_m),
               32'(BLINK & ((k % 2) == 0)));
         check($sformatf("SET_M blink %0d blank_h", k), 32'(blank_h), 0);
      end
      check("s_tick+hs_tick seconds held", 32'(seconds), 0);

      // set 12:34, then async reset from SET_M
      pulse(0, 0, 1, 0);
      pulse(0, 0, 1, 0);
      for (int k = 0; k < 11; k++) pulse(0, 0, 0, 1);
      pulse(0, 0, 1, 0);
      for (int k = 0; k < 34; k++) pulse(0, 0, 0, 1);
      check_time("set 12:34", 12, 34, 0);
      pulse(0, 1, 0, 0);
      check("pre-reset blank_m", 32'(blank_m), 32'(BLINK));
      #3 rst = 1'b1;
      #1;
      check_time("async reset", 0, 0, 0);
      check("async reset mode", 32'(mode), 0);
      check("async reset blank_h", 32'(blank_h), 0);
      check("async reset blank_m", 32'(blank_m), 0);
      @(negedge clk_in);
      rst = 1'b0;
      @(negedge clk_in);
      pulse(1, 0, 0, 0);
      check_time("tick after reset", 0, 0, 1);
      check("mode after reset", 32'(mode), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/clock_timekeeper.md
# clock_timekeeper

Time-of-day controller for the 24-hour clock. Consumes the 1 Hz and 2 Hz single-cycle ticks from the clock divider and sequences the hours/minutes/seconds registers. Runs a small set-mode state machine driven by two button pulses, and drives field-blanking strobes for the display so the field being set blinks.

## Interface
Parameters:
- HOURS_MAX, 23, last hour value before wrap to 0
- MINUTES_MAX, 59, last minute value before wrap
- SECONDS_MAX, 59, last second value before wrap

Ports:
- clk_in  in  1  system clock (50 MHz); sole clock
- rst  in  1  reset, asynchronous, active-high
- s_tick  in  1  one-cycle pulse, once per second, from divider
- hs_tick  in  1  one-cycle pulse, once per half second, from divider
- btn_mode  in  1  one-cycle pulse (already debounced); advances set mode
- btn_inc  in  1  one-cycle pulse (already debounced); increments selected field
- hours  out  5  current hour, 0..HOURS_MAX
- minutes  out  6  current minute, 0..MINUTES_MAX
- seconds  out  6  current second, 0..SECONDS_MAX
- mode  out  2  current state encoding: 0 RUN, 1 SET_H, 2 SET_M
- blank_h  out  1  high: display blanks hour digits
- blank_m  out  1  high: display blanks minute digits
- day_wrap  out  1  one-cycle pulse on the transition 23:59:59 -> 00:00:00

## Operation
- Reset values: hours=0, minutes=0, seconds=0, mode=RUN, blank_h=0, blank_m=0, day_wrap=0, blink phase=0.
- States:
  - RUN: each s_tick increments seconds.
    - Seconds wrapping SECONDS_MAX->0 carries into minutes.
    - Minutes wrapping MINUTES_MAX->0 carries into hours.
    - Hours wrapping HOURS_MAX->0 asserts day_wrap for one cycle. All carries resolve in the same cycle.
    - btn_inc is ignored.
    - btn_mode -> SET_H and clears seconds to 0.
  - SET_H: s_tick is ignored and seconds are held at 0. btn_inc increments hours mod (HOURS_MAX+1), with no carry. btn_mode -> SET_M.
  - SET_M: btn_inc increments minutes mod (MINUTES_MAX+1), with no carry into hours. btn_mode -> RUN.
- On return to RUN, seconds=0. The first s_tick after the return gives seconds=1.
- Simultaneous events:
  - btn_mode with btn_inc in the same cycle: the mode change wins and btn_inc is dropped.
  - btn_mode with s_tick in RUN: transition to SET_H. The tick is discarded and seconds=0.
  - s_tick with hs_tick in a SET state: only hs_tick is acted on (blink).
- Out-of-range values are unreachable. If the register holds >max (e.g. after a parameter mismatch), the next increment loads 0.
- rst asserted mid-operation (any state) returns all outputs to their reset values immediately, asynchronously. Operation resumes in RUN on the first clk_in edge after deassertion.

## Timing
- All outputs are registered. Latency is 1 clk_in cycle from the input pulse to the updated output.
- day_wrap is high in exactly the cycle where hours/minutes/seconds first read 0:0:0 after a wrap.
- mode changes 1 cycle after btn_mode. blank_* is valid in the same cycle as the new mode.
- Inputs are assumed synchronous to clk_in. Pulses longer than 1 cycle count once per cycle high; the producer guarantees single-cycle pulses.

## Configuration
- CLOCK_BLINK_EN defined:
  - A blink phase bit toggles on each hs_tick while in SET_H or SET_M, and is cleared to 0 on every state entry.
  - blank_h = (mode==SET_H) & phase; blank_m = (mode==SET_M) & phase.
  - The field being set therefore blinks at 1 Hz, starting visible.
- CLOCK_BLINK_EN undefined: the phase register is not built, blank_h and blank_m are tied to 0, and hs_tick is unused.

## Structure
- Package clock_pkg:
  - mode_t enum (RUN=2'd0, SET_H=2'd1, SET_M=2'd2).
  - Width constants HOUR_W=5, MIN_W=6, SEC_W=6.
  - Default max constants 23/59/59.
- Sub-module mod_counter:
  - Parameters WIDTH and MAX.
  - Inputs inc and clr; outputs value and wrap (combinational, high when inc & value==MAX).
  - Instantiated three times. The top holds the FSM, carry chaining, blink logic and day_wrap register.

## Test plan
- Reset, then 61 s_tick pulses in RUN -> 00:01:01; day_wrap never high.
- Preload 23:59:58 via SET mode, then 2 s_ticks in RUN -> 23:59:59, then 00:00:00 with day_wrap high exactly 1 cycle.
- btn_mode, 25× btn_inc -> hours=1 (24 wraps to 0); btn_mode, 60× btn_inc -> minutes=0; btn_mode -> mode=RUN, seconds=0.
- btn_mode and btn_inc in the same cycle from RUN -> mode=SET_H, hours unchanged. btn_mode and s_tick together at seconds=30 -> seconds=0.
- With CLOCK_BLINK_EN in SET_M: 4 hs_ticks -> blank_m sequence 1,0,1,0 and blank_h=0 throughout. Without the macro, both blanks stay 0.
- rst pulse in SET_M at 12:34 -> immediately 00:00:00, mode=RUN, blanks 0; after release, the next s_tick gives seconds=1.
